// File: rtl/fsbm_pkg.sv
// Shared definitions for the full-search block-matching datapath:
// window geometry, the loader state encoding and the row-word type.
package fsbm_pkg;

  localparam int unsigned FSBM_PIX_W = 8;
  localparam int unsigned FSBM_WIN   = 19;
  localparam int unsigned FSBM_ROW_W = 152;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } fsbm_state_t;

  typedef logic [FSBM_ROW_W-1:0] fsbm_row_t;

endpackage

// File: rtl/fsbm_row_hold.sv
// One-row holding register between the assembler and the search-window array,
// presenting the row with a valid/ready handshake.
module fsbm_row_hold
  import fsbm_pkg::*;
#(
  parameter int unsigned W = FSBM_ROW_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_word,
  input  logic [4:0]   load_idx,
  input  logic         row_ready,
  output logic         free,
  output logic [W-1:0] buffer1,
  output logic         row_valid,
  output logic [4:0]   row_idx
);

  // Free also when the current row leaves this cycle, so rows can abut.
  assign free = !row_valid || row_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buffer1   <= '0;
      row_valid <= 1'b0;
      row_idx   <= '0;
    end else if (load) begin
      buffer1   <= load_word;
      row_idx   <= load_idx;
      row_valid <= 1'b1;
    end else if (row_valid && row_ready) begin
      row_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fsbm_row_packer.sv
// Assembles a raster byte stream into 19-pixel row words for the search-window
// array, one window (19 rows) per start, with a one-row overlap stage.
module fsbm_row_packer
  import fsbm_pkg::*;
#(
  parameter int unsigned PIX_W = FSBM_PIX_W,
  parameter int unsigned COLS  = FSBM_WIN,
  parameter int unsigned ROWS  = FSBM_WIN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [PIX_W-1:0]      pix_in,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic [COLS*PIX_W-1:0] buffer1,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic [4:0]            row_idx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned RW = COLS * PIX_W;

  fsbm_state_t   state;
  logic [RW-1:0] asm_word;
  logic [RW-1:0] shifted;
  logic [RW-1:0] load_word;
  logic          asm_full;
  logic [4:0]    col;
  logic [4:0]    row;
  logic [4:0]    asm_idx;
  logic [4:0]    load_idx;
  logic          accept;
  logic          last_col;
  logic          last_row;
  logic          complete;
  logic          free;
  logic          load;
  logic          consume;

  assign pix_ready = (state == FILL) && !asm_full;
  assign busy      = (state != IDLE);
  assign accept    = pix_valid && pix_ready;
  assign last_col  = (col == 5'(COLS - 1));
  assign last_row  = (row == 5'(ROWS - 1));
  assign complete  = accept && last_col;
  assign consume   = row_valid && row_ready;
  assign shifted   = {pix_in, asm_word[RW-1:PIX_W]};

  // A parked row (asm_full) blocks input, so it never competes with a completion.
  assign load      = free && (asm_full || complete);
  assign load_word = asm_full ? asm_word : shifted;
  assign load_idx  = asm_full ? asm_idx : row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      asm_word   <= '0;
      asm_full   <= 1'b0;
      asm_idx    <= '0;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (accept) begin
        asm_word <= shifted;
        col      <= last_col ? 5'd0 : col + 5'd1;
      end

      if (complete) begin
        asm_idx <= row;
        row     <= last_row ? 5'd0 : row + 5'd1;
        if (!free) asm_full <= 1'b1;
      end else if (asm_full && free) begin
        asm_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= FILL;
            col   <= '0;
            row   <= '0;
          end
        end
        FILL: begin
          if (complete && last_row) state <= DRAIN;
        end
        DRAIN: begin
          if (consume && !asm_full && (row_idx == 5'(ROWS - 1))) begin
            state      <= IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fsbm_row_hold #(.W(RW)) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_word (load_word),
    .load_idx  (load_idx),
    .row_ready (row_ready),
    .free      (free),
    .buffer1   (buffer1),
    .row_valid (row_valid),
    .row_idx   (row_idx)
  );

endmodule

// File: tb/tb_fsbm_row_packer.sv
// Bench for fsbm_row_packer: windows of pixels are streamed in under several
// row_ready/pix_valid patterns and rows are compared with a window model.
module tb_fsbm_row_packer;

  localparam int PW = 8;
  localparam int NC = 19;
  localparam int NR = 19;
  localparam int RW = NC * PW;
  localparam int NPIX = NC * NR;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PW-1:0] pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic [RW-1:0] buffer1;
  logic          row_valid;
  logic          row_ready;
  logic [4:0]    row_idx;
  logic          busy;
  logic          frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [PW-1:0] win_pix [NPIX];
  logic [RW-1:0] got_rows[$];
  int            got_idx[$];
  logic [RW-1:0] tmp_row;

  always #5 clk = ~clk;

  fsbm_row_packer #(.PIX_W(PW), .COLS(NC), .ROWS(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_in     (pix_in),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .buffer1    (buffer1),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_idx    (row_idx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model row: column c of row r is the (r*19+c)-th pixel of the window.
  function automatic logic [RW-1:0] exp_row(input int r);
    logic [RW-1:0] w;
    w = '0;
    for (int c = 0; c < NC; c++) w[c*PW +: PW] = win_pix[r*NC + c];
    return w;
  endfunction

  task automatic fill_count();
    for (int i = 0; i < NPIX; i++) win_pix[i] = PW'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) win_pix[i] = PW'($urandom);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_buffer1"},    buffer1, '0);
    chk({tag, "_row_valid"},  RW'(row_valid), '0);
    chk({tag, "_row_idx"},    RW'(row_idx), '0);
    chk({tag, "_pix_ready"},  RW'(pix_ready), '0);
    chk({tag, "_busy"},       RW'(busy), '0);
    chk({tag, "_frame_done"}, RW'(frame_done), '0);
  endtask

  // mode 0: row_ready high; 1: hold row 0 for 40 cycles; 2: consume row n as
  // the last pixel of row n+1 enters. rst_at >= 0 aborts with a reset there.
  task automatic run_window(input int mode, input int gap_pct, input int start_at,
                            input int rst_at);
    int acc_cnt, prev_acc, ncyc, fd_cnt, rv_drop;
    int acc19_cyc, rv_first_cyc, first_acc_cyc, last_acc_cyc, fd_cyc, cons18_cyc;
    int stall_left, rel_pending, stall_bad;
    bit rv_seen, stall_done, done, did_rst;
    logic [RW-1:0] snap;

    got_rows.delete();
    got_idx.delete();
    acc_cnt = 0; prev_acc = -1; ncyc = 0; fd_cnt = 0; rv_drop = 0;
    acc19_cyc = -100; rv_first_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
    fd_cyc = -100; cons18_cyc = -1;
    stall_left = 0; rel_pending = 0; stall_bad = 0;
    rv_seen = 0; stall_done = 0; done = 0; did_rst = 0;
    snap = '0;

    start = 1'b1;
    pix_valid = 1'b0;
    row_ready = (mode != 2);
    @(posedge clk); #1;
    start = 1'b0;

    for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
      if (rst_at >= 0 && acc_cnt == rst_at) begin
        rst = 1'b1; pix_valid = 1'b0; row_ready = 1'b0; start = 1'b0;
        #2;
        chk_idle_zero("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        did_rst = 1;
        done = 1;
      end else begin
        start = (acc_cnt == start_at);
        if (acc_cnt < NPIX) begin
          pix_in = win_pix[acc_cnt];
          if (!(pix_valid && acc_cnt == prev_acc))
            pix_valid = ($urandom_range(99) >= 32'(gap_pct));
        end else begin
          pix_valid = 1'b0;
        end
        prev_acc = acc_cnt;

        if (mode == 1) begin
          if (rel_pending == 2) begin
            chk("bp_release_valid", RW'(row_valid), RW'(1));
            chk("bp_release_idx",   RW'(row_idx), RW'(1));
            chk("bp_release_row",   buffer1, exp_row(1));
            rel_pending = 0;
          end
          if (!stall_done && stall_left == 0 && row_valid && row_idx == 5'd0) begin
            stall_left = 40;
            snap = buffer1;
          end
          if (stall_left > 0) begin
            row_ready = 1'b0;
            if (buffer1 !== snap || row_idx !== 5'd0) stall_bad++;
            stall_left--;
            if (stall_left == 0) begin
              stall_done = 1;
              chk("bp_pix_ready_low", RW'(pix_ready), '0);
              rel_pending = 1;
            end
          end else begin
            row_ready = 1'b1;
            if (rel_pending == 1) rel_pending = 2;
          end
        end else if (mode == 2) begin
          row_ready = (acc_cnt >= NPIX) || ((acc_cnt % NC == NC - 1) && pix_valid);
        end else begin
          row_ready = 1'b1;
        end

        @(negedge clk);
        ncyc++;
        if (pix_valid && pix_ready) begin
          if (acc_cnt == 0) first_acc_cyc = ncyc;
          if (acc_cnt == NC - 1) acc19_cyc = ncyc;
          last_acc_cyc = ncyc;
          acc_cnt++;
        end
        if (row_valid && !rv_seen) begin
          rv_seen = 1;
          rv_first_cyc = ncyc;
        end
        if (rv_seen && !row_valid && busy) rv_drop++;
        if (row_valid && row_ready) begin
          got_rows.push_back(buffer1);
          got_idx.push_back(int'(row_idx));
          if (row_idx == 5'(NR - 1)) cons18_cyc = ncyc;
        end
        if (frame_done) begin
          if (fd_cnt == 0) fd_cyc = ncyc;
          fd_cnt++;
        end
        if (fd_cnt > 0) done = 1;
        @(posedge clk); #1;
      end
    end

    chk("window_finished", RW'(done), RW'(1));
    if (!did_rst) begin
      pix_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (frame_done) fd_cnt++;
        @(posedge clk); #1;
      end
      chk("row_count", RW'(got_rows.size()), RW'(NR));
      for (int r = 0; r < got_rows.size() && r < NR; r++) begin
        chk($sformatf("row%0d_data", r), got_rows[r], exp_row(r));
        chk($sformatf("row%0d_idx", r), RW'(got_idx[r]), RW'(r));
      end
      chk("first_row_latency", RW'(rv_first_cyc - acc19_cyc), RW'(1));
      chk("frame_done_pulses", RW'(fd_cnt), RW'(1));
      chk("frame_done_timing", RW'(fd_cyc - cons18_cyc), RW'(1));
      chk("end_busy", RW'(busy), '0);
      chk("end_row_valid", RW'(row_valid), '0);
      chk("end_pix_ready", RW'(pix_ready), '0);
      if (mode == 1) chk("bp_hold_stable", RW'(stall_bad), '0);
      if (mode == 2) begin
        chk("sim_no_bubble", RW'(rv_drop), '0);
        chk("sim_no_stall", RW'(last_acc_cyc - first_acc_cyc), RW'(NPIX - 1));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_in = '0; pix_valid = 1'b0; row_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle_zero("post_reset");

    fill_count();
    run_window(0, 0, -1, -1);
    if (got_rows.size() == NR) begin
      tmp_row = got_rows[0];
      chk("row0_col0", RW'(tmp_row[7:0]), RW'(8'h00));
      chk("row0_col18", RW'(tmp_row[151:144]), RW'(8'h12));
      tmp_row = got_rows[NR-1];
      chk("row18_col0", RW'(tmp_row[7:0]), RW'(8'h56));
    end else begin
      chk("plain_rows_present", RW'(got_rows.size()), RW'(NR));
    end

    fill_random();
    run_window(1, 0, -1, -1);

    fill_count();
    run_window(0, 50, -1, -1);

    fill_random();
    run_window(0, 0, 100, -1);

    fill_random();
    run_window(0, 0, -1, 7 * NC + 5);
    fill_random();
    run_window(0, 0, -1, -1);

    fill_random();
    run_window(2, 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
